// File: rtl/mem_inc_pkg.sv
// Shared memory-access types for the data-memory path.
// Decoded access parameters, size codes, controller state and fault flags.
package mem_inc;

  typedef struct packed {
    logic       op;
    logic [1:0] access_size;
    logic       read_unsigned;
  } mem_params_t;

  localparam logic [1:0] ACCESS_BYTE = 2'd0;
  localparam logic [1:0] ACCESS_HALF = 2'd1;
  localparam logic [1:0] ACCESS_WORD = 2'd2;
  localparam logic [1:0] ACCESS_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_ctrl_state_t;

  typedef struct packed {
    logic misaligned;
    logic timeout;
  } mem_fault_t;

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering, load extension and alignment check.
// Purely combinational; shared with a future fetch path.
module mem_lane_align
  import mem_inc::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic        sext_b;
  logic        sext_h;

  assign shifted = bus_rdata >> {offset, 3'b000};
  assign sext_b  = ~is_unsigned & shifted[7];
  assign sext_h  = ~is_unsigned & shifted[15];

  always_comb begin
    be         = 4'b0000;
    bus_wdata  = 32'h0;
    rdata      = 32'h0;
    misaligned = 1'b0;
    unique case (1'b1)
      (size == ACCESS_BYTE): begin
        be        = 4'b0001 << offset;
        bus_wdata = {4{wdata[7:0]}};
        rdata     = {{24{sext_b}}, shifted[7:0]};
      end
      (size == ACCESS_HALF): begin
        be         = 4'b0011 << offset;
        bus_wdata  = {2{wdata[15:0]}};
        rdata      = {{16{sext_h}}, shifted[15:0]};
        misaligned = offset[0];
      end
      (size == ACCESS_WORD): begin
        be         = 4'b1111;
        bus_wdata  = wdata;
        rdata      = shifted;
        misaligned = |offset;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: one outstanding req/ack access,
// with alignment faults, bus timeout and load-data extension.
module mem_access_ctrl
  import mem_inc::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  mem_params_t mem_params,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault_misaligned,
  output logic        fault_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  mem_ctrl_state_t state, next;
  mem_params_t     lat_params;
  logic [1:0]      lat_off;
  logic [CW-1:0]   cnt;
  mem_fault_t      fault;

  logic        is_idle;
  logic        accept;
  logic        timed_out;
  logic [1:0]  sel_size;
  logic [1:0]  sel_off;
  logic        sel_uns;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;
  logic        la_mis;

  assign is_idle   = (state == IDLE);
  assign accept    = is_idle & start;
  assign timed_out = (cnt == CNT_LAST);

  // Live request decides alignment in IDLE; latched copy extends load data.
  assign sel_size = is_idle ? mem_params.access_size : lat_params.access_size;
  assign sel_off  = is_idle ? addr[1:0] : lat_off;
  assign sel_uns  = is_idle ? mem_params.read_unsigned
                            : lat_params.read_unsigned;

  mem_lane_align u_align (
    .size        (sel_size),
    .offset      (sel_off),
    .is_unsigned (sel_uns),
    .wdata       (wdata),
    .bus_rdata   (bus_rdata),
    .be          (la_be),
    .bus_wdata   (la_wdata),
    .rdata       (la_rdata),
    .misaligned  (la_mis)
  );

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (start) next = la_mis ? DONE : REQ;
      REQ:  if (bus_ack || timed_out) next = DONE;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_params <= '0;
      lat_off    <= 2'b00;
      cnt        <= '0;
      fault      <= '0;
      rdata      <= 32'h0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'b0000;
      bus_wdata  <= 32'h0;
    end else begin
      state <= next;
      if (accept) begin
        lat_params <= mem_params;
        lat_off    <= addr[1:0];
        cnt        <= '0;
        fault      <= '0;
        if (la_mis) begin
          fault.misaligned <= 1'b1;
          rdata            <= 32'h0;
        end else begin
          bus_req   <= 1'b1;
          bus_we    <= ~mem_params.op;
          bus_addr  <= {addr[31:2], 2'b00};
          bus_be    <= la_be;
          bus_wdata <= la_wdata;
        end
      end else if (state == REQ) begin
        if (bus_ack) begin
          bus_req <= 1'b0;
          rdata   <= lat_params.op ? la_rdata : 32'h0;
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (timed_out) begin
            bus_req       <= 1'b0;
            fault.timeout <= 1'b1;
            rdata         <= 32'h0;
          end
        end
      end
    end
  end

  assign busy             = ~is_idle;
  assign done             = (state == DONE);
  assign fault_misaligned = fault.misaligned;
  assign fault_timeout    = fault.timeout;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences one data-memory access per request from the execute stage over a single-outstanding req/ack data bus. Consumes the decoded `mem_params_t` (R/!W op, access size, unsigned flag), the effective address and the store data. Performs alignment checking, byte-lane steering, the bus handshake with timeout, and load-data extension. Sits between decode/execute and the data bus; the pipeline stalls on `busy`.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles `bus_req` is held without `bus_ack` before the access faults. Must be ≥1.
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — request a new access; sampled only in IDLE.
- `mem_params`  in  mem_params_t  — `op` (1 = read, 0 = write), `access_size` (0 = byte, 1 = half, 2 = word, 3 = reserved), `read_unsigned`.
- `addr`  in  32  — byte address of the access.
- `wdata`  in  32  — store data, right-justified.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle completion pulse.
- `rdata`  out  32  — extended load data; held from `done` until the next accepted `start`.
- `fault_misaligned`  out  1  — qualified by `done`.
- `fault_timeout`  out  1  — qualified by `done`.
- `bus_req`  out  1 — bus request.
- `bus_we`  out  1 — write enable.
- `bus_addr`  out  32  — `{addr[31:2], 2'b00}`.
- `bus_be`  out  4 — byte enables.
- `bus_wdata`  out  32 — lane-replicated store data.
- `bus_ack`  in  1 — bus acknowledge.
- `bus_rdata`  in  32 — bus read data.

## Operation
- States:
  - IDLE → on `start`, latch the inputs.
    - If misaligned → DONE (no bus activity).
    - Otherwise → REQ.
  - REQ → on `bus_ack` or timeout → DONE.
  - DONE → IDLE, unconditionally.
- Misaligned conditions:
  - size 1 with `addr[0]` = 1.
  - size 2 with `addr[1:0]` ≠ 0.
  - size 3, for any address.
- Byte enables (`bus_be`), with `o = addr[1:0]`:
  - byte: `4'b0001 << o`.
  - half: `4'b0011 << o`.
  - word: `4'b1111`.
- Store data (`bus_wdata`):
  - byte: `{4{wdata[7:0]}}`.
  - half: `{2{wdata[15:0]}}`.
  - word: `wdata`.
- Load data:
  - `bus_rdata >> (8*o)`, then take the low 8 or 16 bits.
  - Sign-extend, or zero-extend if `read_unsigned`.
  - Word loads ignore `read_unsigned`.
  - Captured on the acking cycle.
- Writes, faults and timeouts load `rdata` = 0.
- `start` while `busy` is ignored; there is no queueing.
- Bus outputs are registered, loaded on IDLE→REQ, and held constant throughout REQ.
- `bus_req` deasserts on entry to DONE.

## Timing
- Reset value of every output is 0. State resets to IDLE and the timeout counter to 0.
- Aligned access, `start` accepted at edge 0:
  - `bus_req` is high in cycle 1.
  - With ack in cycle 1, `done` is high in cycle 2. Minimum latency is 2 cycles.
  - Each wait cycle adds 1.
- Misaligned access: `done` plus `fault_misaligned` in cycle 1; `bus_req` never asserts.
- Timeout:
  - The counter increments for each REQ cycle without ack.
  - `bus_req` stays high for exactly `TIMEOUT_CYCLES` cycles.
  - Ack on the last of those cycles is accepted: ack wins over timeout in the same cycle.
  - Otherwise → DONE with `fault_timeout`.
- `done` and `busy` are both high in DONE.
- `start` in the DONE cycle is ignored. The earliest next acceptance is the following IDLE cycle.
- Reset mid-access: all outputs and state return to reset values at the next edge. Any `bus_ack` in or after that cycle is ignored, and no `done` pulse is issued.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` and saturates; it never wraps.

## Structure
- Shared package `mem_inc`:
  - `mem_params_t` (existing).
  - New constants `ACCESS_BYTE`/`ACCESS_HALF`/`ACCESS_WORD`/`ACCESS_RSVD`.
  - New enum `mem_ctrl_state_t` {IDLE, REQ, DONE}.
  - New struct `mem_fault_t` {misaligned, timeout}.
- One combinational sub-module, `mem_lane_align`:
  - Inputs: size, offset, unsigned flag, `wdata`, `bus_rdata`.
  - Outputs: be, bus wdata, extended rdata, misaligned.
  - Reusable by a future fetch path.
- The top level holds the FSM, input latches, timeout counter and output registers.

## Test plan
- Byte load, `addr` = 0x1003, signed, `bus_rdata` = 0x80FF_FF7F, ack after 2 waits → `bus_be` = 0x8, `bus_addr` = 0x1000, `done` in cycle 4, `rdata` = 0xFFFF_FF80. Same access unsigned → 0x0000_0080.
- Half store, `addr` = 0x2002, `wdata` = 0xDEAD_BEEF, immediate ack → `bus_we` = 1, `bus_be` = 0xC, `bus_wdata` = 0xBEEF_BEEF, `done` in cycle 2, `rdata` = 0.
- Word load, `addr` = 0x3001 → `done` in cycle 1, `fault_misaligned` = 1, `bus_req` never high. Size 3 at 0x3000 → same result.
- `TIMEOUT_CYCLES` = 4, no ack → `bus_req` high for exactly 4 cycles, then `done` plus `fault_timeout`. Ack on the 4th cycle → normal completion, no fault.
- `reset` asserted in the 2nd REQ cycle with ack in the same cycle → all outputs 0 next cycle, no `done`. A new `start` after reset completes normally.
- `start` held continuously with back-to-back word loads → each access accepted only in IDLE, one `done` per access, `rdata` stable between `done` pulses.
